// File: rtl/asymmetric_pack_fifo.sv
// Narrow-to-wide packing FIFO: RATIO narrow beats pack LSB-first into one wide entry,
// stored in a RAM and read through a two-stage pipeline. Optional flush: ASYM_PACK_FIFO_FLUSH_EN.
module asymmetric_pack_fifo #(
   parameter int unsigned WIDTH_IN      = 4,
   parameter int unsigned WIDTH_OUT     = 16,
   parameter int unsigned DEPTH_OUT     = 256,
   parameter int unsigned ADDRWIDTH_OUT = 8,
   parameter              RAM_STYLE     = "auto"
) (
`ifdef ASYM_PACK_FIFO_FLUSH_EN
   input  logic                     flush,
`endif
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH_IN-1:0]      s_tdata,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   output logic [WIDTH_OUT-1:0]     m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic [ADDRWIDTH_OUT:0]   count
);

   localparam int unsigned RATIO = WIDTH_OUT / WIDTH_IN;
   localparam int unsigned LANEW = $clog2(RATIO);
   localparam int unsigned CW    = ADDRWIDTH_OUT + 1;

   (* ram_style = RAM_STYLE *) logic [WIDTH_OUT-1:0] mem [DEPTH_OUT];

   logic [LANEW-1:0]         lane_q, lane_d;
   logic [WIDTH_OUT-1:0]     pack_q, pack_d, word_c;
   logic [ADDRWIDTH_OUT-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]            count_q, count_d, unread_q, unread_d;
   logic                     s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [WIDTH_OUT-1:0]     s1_data_q, s2_data_q, s2_data_d;
   logic                     accept, commit, pop, s1_adv, issue;

   assign s_tready = (count_q < CW'(DEPTH_OUT));
   assign m_tvalid = s2_valid_q;
   assign m_tdata  = s2_data_q;
   assign count    = count_q;

   // Packing, commit decision and read-pipeline control
   always_comb begin
      accept = s_tvalid && s_tready;
      pop    = s2_valid_q && m_tready;
      s1_adv = s1_valid_q && (!s2_valid_q || pop);
      issue  = (unread_q != '0) && (!s1_valid_q || s1_adv);

      word_c = pack_q;
      for (int k = 0; k < RATIO; k++) begin
         if (accept && (lane_q == LANEW'(k))) word_c[k*WIDTH_IN +: WIDTH_IN] = s_tdata;
      end

      commit = accept && (lane_q == LANEW'(RATIO - 1));
`ifdef ASYM_PACK_FIFO_FLUSH_EN
      // A flush folds in a coincident beat, so an entry holding only that beat still commits
      if (flush && ((lane_q != '0) || accept)) commit = 1'b1;
`endif

      lane_d = lane_q;
      pack_d = word_c;
      if (commit) begin
         lane_d = '0;
         pack_d = '0;
      end else if (accept) begin
         lane_d = lane_q + LANEW'(1);
      end

      wptr_d = commit ? wptr_q + ADDRWIDTH_OUT'(1) : wptr_q;
      rptr_d = issue  ? rptr_q + ADDRWIDTH_OUT'(1) : rptr_q;

      count_d = count_q;
      if (commit && !pop)      count_d = count_q + CW'(1);
      else if (!commit && pop) count_d = count_q - CW'(1);

      unread_d = unread_q;
      if (commit && !issue)      unread_d = unread_q + CW'(1);
      else if (!commit && issue) unread_d = unread_q - CW'(1);

      s1_valid_d = s1_valid_q;
      if (issue)       s1_valid_d = 1'b1;
      else if (s1_adv) s1_valid_d = 1'b0;

      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      if (s1_adv) begin
         s2_valid_d = 1'b1;
         s2_data_d  = s1_data_q;
      end else if (pop) begin
         s2_valid_d = 1'b0;
      end
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q     <= '0;
         pack_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         unread_q   <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         lane_q     <= lane_d;
         pack_q     <= pack_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         unread_q   <= unread_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
      end
   end

   // Storage and stage-1 registered read; contents survive reset
   always_ff @(posedge clk) begin
      if (commit && !rst) mem[wptr_q] <= word_c;
      if (issue)          s1_data_q   <= mem[rptr_q];
   end

endmodule

// File: tb/tb_asymmetric_pack_fifo.sv
// Randomised + directed bench for asymmetric_pack_fifo against a queue-based model.
module tb_asymmetric_pack_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [15:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic [2:0]  count;
   logic        flush;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] mq[$];
   logic [3:0]  beats[$];
   int          n_pop;
   logic        obs_tv;
   logic [15:0] obs_td;
   logic        prev_hold;
   logic [15:0] prev_td;

   asymmetric_pack_fifo #(
      .WIDTH_IN(4), .WIDTH_OUT(16), .DEPTH_OUT(4), .ADDRWIDTH_OUT(2), .RAM_STYLE("auto")
   ) dut (
`ifdef ASYM_PACK_FIFO_FLUSH_EN
      .flush(flush),
`endif
      .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] pack_beats();
      logic [15:0] w = '0;
      for (int k = 0; k < beats.size(); k++) w = w | (16'(beats[k]) << (4 * k));
      return w;
   endfunction

   // One cycle: drive, observe before the edge, then advance the model across the edge
   task automatic step(input logic v, input logic [3:0] d, input logic rdy,
                       input logic r, input logic fl);
      logic acc;
      @(negedge clk);
      s_tvalid = v; s_tdata = d; m_tready = rdy; rst = r; flush = fl;
      #1;
      obs_tv = m_tvalid;
      obs_td = m_tdata;
      check("count", 32'(count), 32'(mq.size()));
      check("s_tready", 32'(s_tready), 32'(mq.size() < 4));
      if (mq.size() == 0) check("m_tvalid_empty", 32'(m_tvalid), 32'(0));
      if (prev_hold) begin
         check("hold_valid", 32'(m_tvalid), 32'(1));
         check("hold_data", 32'(m_tdata), 32'(prev_td));
      end
      acc = v && (mq.size() < 4);
      if (m_tvalid && rdy && mq.size() != 0) begin
         check("m_tdata", 32'(m_tdata), 32'(mq[0]));
         void'(mq.pop_front());
         n_pop++;
      end
      if (acc) begin
         beats.push_back(d);
         if (beats.size() == 4) begin
            mq.push_back(pack_beats());
            beats.delete();
         end
      end
`ifdef ASYM_PACK_FIFO_FLUSH_EN
      if (fl && beats.size() != 0) begin
         mq.push_back(pack_beats());
         beats.delete();
      end
`endif
      prev_hold = m_tvalid && !rdy && !r;
      prev_td   = m_tdata;
      if (r) begin
         mq.delete();
         beats.delete();
         prev_hold = 1'b0;
      end
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 40 && mq.size() != 0; i++) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      if (mq.size() != 0) check("drain_timeout", 32'(mq.size()), 32'(0));
      for (int j = 0; j < 3; j++) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      int first_hi, n_hi, acc_cnt, pops0, cyc;
      rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; flush = 1'b0;
      n_pop = 0; prev_hold = 1'b0; obs_tv = 1'b0; obs_td = '0; prev_td = '0;
      step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      check("reset_m_tdata", 32'(obs_td), 32'(0));
      check("reset_m_tvalid", 32'(obs_tv), 32'(0));

      // Reset mid-entry at lane 2
      step(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
      step(1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      check("rst_mid_count", 32'(count), 32'(0));
      check("rst_mid_s_tready", 32'(s_tready), 32'(1));
      check("rst_mid_m_tvalid", 32'(obs_tv), 32'(0));

      // Packing and latency: 1,2,3,4 -> 16'h4321, valid on third observation after commit
      for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
      first_hi = -1; n_hi = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
         if (obs_tv) begin
            n_hi++;
            if (first_hi < 0) begin
               first_hi = i;
               check("pack_data", 32'(obs_td), 32'h4321);
            end
         end
      end
      check("pack_latency", 32'(first_hi), 32'(2));
      check("pack_valid_cycles", 32'(n_hi), 32'(1));

      // Full: 16 beats fill 4 entries, 17th held, one pop reopens input
      for (int i = 0; i < 17; i++) step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      check("full_count", 32'(count), 32'(4));
      check("full_s_tready", 32'(s_tready), 32'(0));
      step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
      check("full_held", 32'(s_tready), 32'(0));
      step(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
      check("full_pop_valid", 32'(obs_tv), 32'(1));
      step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
      check("after_pop_count", 32'(count), 32'(3));
      check("after_pop_s_tready", 32'(s_tready), 32'(1));
      drain();
      // The lone accepted 9 is a partial entry; complete it so the next tests start clean
      for (int i = 0; i < 3; i++) step(1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
      drain();

      // Simultaneous commit and pop at count 2
      for (int i = 0; i < 11; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0, 1'b0);
      check("simul_pre_count", 32'(count), 32'(2));
      step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
      check("simul_pop_valid", 32'(obs_tv), 32'(1));
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      check("simul_count", 32'(count), 32'(2));
      drain();

      // Wrap-around: 48 beats of i mod 16 under random handshakes
      pops0 = n_pop; acc_cnt = 0; cyc = 0;
      while (acc_cnt < 48 && cyc < 3000) begin
         logic v, rdy, will;
         v    = 1'($urandom_range(0, 1));
         rdy  = 1'($urandom_range(0, 1));
         will = v && (mq.size() < 4);
         step(v, 4'(acc_cnt % 16), rdy, 1'b0, 1'b0);
         if (will) acc_cnt++;
         cyc++;
      end
      check("wrap_accepted", 32'(acc_cnt), 32'(48));
      drain();
      check("wrap_pops", 32'(n_pop - pops0), 32'(12));

`ifdef ASYM_PACK_FIFO_FLUSH_EN
      pops0 = n_pop;
      step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
      step(1'b1, 4'hB, 1'b1, 1'b0, 1'b0);
      step(1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
      first_hi = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
         if (obs_tv) begin
            first_hi = 1;
            check("flush_data", 32'(obs_td), 32'h0CBA);
         end
      end
      check("flush_seen", 32'(first_hi), 32'(1));
      check("flush_pops", 32'(n_pop - pops0), 32'(1));
      check("flush_count", 32'(count), 32'(0));
      // Flush with nothing pending does nothing
      step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
      drain();
      check("flush_idle_count", 32'(count), 32'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
